uart_axis_rx: RTL and testbench

UART receiver that recovers bytes from a serial line and presents them as an AXI-Stream master with TLAST framing. It is the receive-side counterpart of the FIFO-buffered UART transmitter and consumes the serial stream that transmitter produces, for example in a loopback or a link partner. Packet boundaries (TLAST) are rebuilt from line idle time. Framing, overrun and optional parity errors are reported as one-cycle pulses.

---
 rtl/uart_pkg.sv | 32 +++
 rtl/uart_baud_tick.sv | 31 +++
 rtl/uart_axis_rx.sv | 234 +++++++++++++++++++++++
 tb/tb_uart_axis_rx.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: receiver state encoding and sizing helpers shared by the
// UART receive path (divider, idle timeout and counter widths).
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } rx_state_t;

  function automatic int calc_div(int clk_rate, int baud, int os);
    longint den;
    longint q;
    den = longint'(baud) * longint'(os);
    q = (longint'(clk_rate) + den / 2) / den;
    return (q < 1) ? 1 : int'(q);
  endfunction

  function automatic int calc_idle_ticks(
    int chars, int width, int os, bit par
  );
    return chars * (width + (par ? 3 : 2)) * os;
  endfunction

  function automatic int cnt_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running oversample tick divider,
// realigned to the frame by the restart input.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int CW = cnt_w(DIV);
  localparam logic [CW-1:0] C_LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (restart || cnt == C_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = !restart && (cnt == C_LAST);

endmodule

// File: rtl/uart_axis_rx.sv
// uart_axis_rx: UART receiver, AXI-Stream master, TLAST from idle time.
// Define UART_RX_PARITY_EN for an even parity bit after the data bits.
module uart_axis_rx
  import uart_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int CLK_RATE   = 50000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int IDLE_CHARS = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             uart_rx,
  output logic [WIDTH-1:0] m_axis_data,
  output logic             m_axis_valid,
  output logic             m_axis_last,
  input  logic             m_axis_ready,
  output logic             frame_err,
  output logic             overrun,
  output logic             parity_err
);

`ifdef UART_RX_PARITY_EN
  localparam bit PAR = 1'b1;
  localparam rx_state_t DATA_NEXT = S_PARITY;
`else
  localparam bit PAR = 1'b0;
  localparam rx_state_t DATA_NEXT = S_STOP;
`endif

  localparam int DIV = calc_div(CLK_RATE, BAUD, OVERSAMPLE);
  localparam int IDLE_TICKS =
    calc_idle_ticks(IDLE_CHARS, WIDTH, OVERSAMPLE, PAR);
  localparam int OS_W = cnt_w(OVERSAMPLE);
  localparam int BIT_W = cnt_w(WIDTH);
  localparam int IT_W = cnt_w(IDLE_TICKS + 1);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0] OS_HALF = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
  localparam logic [IT_W-1:0] IT_LAST = IT_W'(IDLE_TICKS - 1);

  logic [1:0] sync_q;
  logic [1:0] flush_q;
  logic       rx_s;
  logic       rx_prev;
  logic       armed;
  logic       fall;

  // armed stays low until the real line has been seen high after reset,
  // so a frame cut by reset cannot produce a start edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q  <= 2'b11;
      flush_q <= 2'b00;
      rx_prev <= 1'b1;
      armed   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], uart_rx};
      flush_q <= {flush_q[0], 1'b1};
      rx_prev <= rx_s;
      armed   <= armed | (flush_q[1] & rx_s);
    end
  end

  assign rx_s = sync_q[1];
  assign fall = armed & rx_prev & ~rx_s;

  rx_state_t        state;
  logic [OS_W-1:0]  os_cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic [WIDTH-1:0] shreg;
  logic             par_bad;
  logic             tick;
  logic             start_det;
  logic             start_ok;
  logic             stop_smp;
  logic             byte_ok;

  assign start_det = (state == S_IDLE) && fall;
  assign start_ok = (state == S_START) && tick &&
                    (os_cnt == OS_HALF) && !rx_s;
  assign stop_smp = (state == S_STOP) && tick && (os_cnt == OS_LAST);
  assign byte_ok = stop_smp && rx_s && !par_bad;

  uart_baud_tick #(
    .DIV(DIV)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .restart(start_det),
    .tick   (tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      os_cnt     <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_bad    <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (fall) begin
            state   <= S_START;
            os_cnt  <= '0;
            par_bad <= 1'b0;
          end
        end
        S_START: begin
          if (tick) begin
            if (os_cnt == OS_HALF) begin
              os_cnt  <= '0;
              bit_cnt <= '0;
              state   <= rx_s ? S_IDLE : S_DATA;
            end else begin
              os_cnt <= os_cnt + 1'b1;
            end
          end
        end
        S_DATA: begin
          if (tick) begin
            if (os_cnt == OS_LAST) begin
              os_cnt  <= '0;
              shreg   <= {rx_s, shreg[WIDTH-1:1]};
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == BIT_LAST) state <= DATA_NEXT;
            end else begin
              os_cnt <= os_cnt + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (tick) begin
            if (os_cnt == OS_LAST) begin
              os_cnt  <= '0;
              par_bad <= (^shreg) != rx_s;
              state   <= S_STOP;
            end else begin
              os_cnt <= os_cnt + 1'b1;
            end
          end
        end
`endif
        S_STOP: begin
          if (tick) begin
            if (os_cnt == OS_LAST) begin
              os_cnt <= '0;
              if (rx_s) begin
                state      <= S_IDLE;
                parity_err <= par_bad;
              end else begin
                state     <= S_BREAK;
                frame_err <= 1'b1;
              end
            end else begin
              os_cnt <= os_cnt + 1'b1;
            end
          end
        end
        S_BREAK: begin
          if (rx_s) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  logic             pend_full;
  logic             pend_dec;
  logic             pend_last;
  logic [WIDTH-1:0] pend_data;
  logic [IT_W-1:0]  idle_cnt;
  logic             idle_cnt_en;
  logic             idle_to;
  logic             decide;
  logic             move;

  assign idle_cnt_en = (state == S_IDLE) && pend_full && !pend_dec && tick;
  assign idle_to = idle_cnt_en && (idle_cnt == IT_LAST);
  assign decide = pend_full && !pend_dec && (start_ok || idle_to);
  assign move = pend_full && (pend_dec || decide) &&
                (!m_axis_valid || m_axis_ready);

  // A completing byte may refill pending in the cycle it drains.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_full    <= 1'b0;
      pend_dec     <= 1'b0;
      pend_last    <= 1'b0;
      pend_data    <= '0;
      idle_cnt     <= '0;
      m_axis_valid <= 1'b0;
      m_axis_last  <= 1'b0;
      m_axis_data  <= '0;
      overrun      <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (start_det) begin
        idle_cnt <= '0;
      end else if (idle_cnt_en) begin
        idle_cnt <= idle_cnt + 1'b1;
      end
      if (m_axis_valid && m_axis_ready) m_axis_valid <= 1'b0;
      if (move) begin
        m_axis_valid <= 1'b1;
        m_axis_data  <= pend_data;
        m_axis_last  <= pend_dec ? pend_last : idle_to;
        pend_full    <= 1'b0;
        pend_dec     <= 1'b0;
      end else if (decide) begin
        pend_dec  <= 1'b1;
        pend_last <= idle_to;
      end
      if (byte_ok) begin
        if (!pend_full || move) begin
          pend_full <= 1'b1;
          pend_dec  <= 1'b0;
          pend_last <= 1'b0;
          pend_data <= shreg;
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_axis_rx.sv
// tb_uart_axis_rx: directed and random UART frames checked against a
// byte-level model of beats, TLAST and error pulses.
`timescale 1ns/1ps
module tb_uart_axis_rx;

  localparam int W = 8;
  localparam int OS = 16;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int IDLE_T = 2 * (W + (PAR ? 3 : 2)) * OS;

  typedef struct {
    logic [W-1:0] d;
    bit           bad_stop;
    bit           bad_par;
    int           gap;
  } frame_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         uart_rx = 1'b1;
  logic         m_axis_ready = 1'b1;
  logic [W-1:0] m_axis_data;
  logic         m_axis_valid;
  logic         m_axis_last;
  logic         frame_err;
  logic         overrun;
  logic         parity_err;

  int     tests = 0;
  int     fails = 0;
  longint cyc = 0;
  longint stop_mid = 0;
  longint rise_cyc = 0;
  int     beats = 0;
  int     ferr_cnt = 0;
  int     perr_cnt = 0;
  int     ovr_cnt = 0;
  int     exp_ferr = 0;
  int     exp_perr = 0;
  int     exp_ovr = 0;
  int     b0;
  int     f0;
  logic [W:0] exp_q[$];
  logic [W:0] last_beat = '0;
  logic [W:0] e;
  frame_t fr_q[$];
  bit     rand_rdy = 1'b0;

  uart_axis_rx #(
    .WIDTH     (W),
    .CLK_RATE  (50000000),
    .BAUD      (3125000),
    .OVERSAMPLE(OS),
    .IDLE_CHARS(2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .uart_rx     (uart_rx),
    .m_axis_data (m_axis_data),
    .m_axis_valid(m_axis_valid),
    .m_axis_last (m_axis_last),
    .m_axis_ready(m_axis_ready),
    .frame_err   (frame_err),
    .overrun     (overrun),
    .parity_err  (parity_err)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic frame_t mk(logic [W-1:0] d, bit bs, bit bp, int gap);
    frame_t f;
    f.d = d;
    f.bad_stop = bs;
    f.bad_par = bp;
    f.gap = gap;
    return f;
  endfunction

  // Byte-level model: bad frames count errors, a stalled sink holds two
  // bytes, TLAST set when the idle after the stop midpoint reaches IDLE_T.
  function automatic void model(input bit stall);
    int  kept;
    bit  last;
    kept = 0;
    for (int i = 0; i < fr_q.size(); i++) begin
      if (fr_q[i].bad_stop) begin
        exp_ferr++;
        continue;
      end
      if (PAR && fr_q[i].bad_par) begin
        exp_perr++;
        continue;
      end
      if (stall && kept >= 2) begin
        exp_ovr++;
        continue;
      end
      kept++;
      last = (i == fr_q.size() - 1) ||
             (OS / 2 + OS * fr_q[i].gap >= IDLE_T);
      exp_q.push_back({last, fr_q[i].d});
    end
  endfunction

  task automatic drive(input logic v, input int n);
    #1 uart_rx = v;
    if (n > 0) repeat (n) @(posedge clk);
  endtask

  task automatic send(input frame_t f);
    logic [W-1:0] d;
    d = f.d;
    drive(1'b0, OS);
    for (int b = 0; b < W; b++) drive(d[b], OS);
    if (PAR) drive((^d) ^ f.bad_par, OS);
    stop_mid = cyc + OS / 2;
    drive(!f.bad_stop, OS);
    drive(1'b1, OS * f.gap);
  endtask

  task automatic run(input string name, input bit stall);
    model(stall);
    foreach (fr_q[i]) send(fr_q[i]);
    if (stall) begin
      repeat (40) @(posedge clk);
      #1 m_axis_ready = 1'b1;
    end
    repeat (IDLE_T + 100) @(posedge clk);
    for (int t = 0; t < 5000 && exp_q.size() > 0; t++) @(posedge clk);
    #1;
    check({name, "_drain"}, exp_q.size(), 0);
    check({name, "_frame_err_cnt"}, ferr_cnt, exp_ferr);
    check({name, "_parity_err_cnt"}, perr_cnt, exp_perr);
    check({name, "_overrun_cnt"}, ovr_cnt, exp_ovr);
    fr_q.delete();
  endtask

  logic         pv = 1'b0;
  logic         pr = 1'b0;
  logic         pl = 1'b0;
  logic         pfe = 1'b0;
  logic         ppe = 1'b0;
  logic         pov = 1'b0;
  logic [W-1:0] pd = '0;

  always @(negedge clk) begin
    if (rst) begin
      if (pv && !pr) begin
        check("hold_valid", m_axis_valid, 1);
        check("hold_data", m_axis_data, pd);
        check("hold_last", m_axis_last, pl);
      end
      if (m_axis_valid && !pv) rise_cyc = cyc;
      if (m_axis_valid && m_axis_ready) begin
        beats++;
        last_beat = {m_axis_last, m_axis_data};
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL extra_beat: got data=%h last=%b, want no beat",
                   m_axis_data, m_axis_last);
        end else begin
          e = exp_q.pop_front();
          check("beat", {m_axis_last, m_axis_data}, e);
        end
      end
      if (frame_err) begin
        ferr_cnt++;
        check("frame_err_width", pfe, 0);
      end
      if (parity_err) begin
        perr_cnt++;
        check("parity_err_width", ppe, 0);
      end
      if (overrun) begin
        ovr_cnt++;
        check("overrun_width", pov, 0);
      end
    end
    pv = m_axis_valid;
    pr = m_axis_ready;
    pd = m_axis_data;
    pl = m_axis_last;
    pfe = frame_err;
    ppe = parity_err;
    pov = overrun;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (5) @(posedge clk);
    #1;
    check("reset_outputs", {m_axis_valid, m_axis_last, m_axis_data,
                            frame_err, overrun, parity_err}, 0);
    rst = 1'b1;
    repeat (20) @(posedge clk);

    // single byte then idle
    b0 = beats;
    fr_q.push_back(mk(8'hA5, 1'b0, 1'b0, 40));
    run("s1", 1'b0);
    check("s1_beats", beats - b0, 1);
    check("s1_beat", last_beat, 9'h1A5);
    check("s1_latency", (rise_cyc - stop_mid >= 321) &&
                        (rise_cyc - stop_mid <= 324), 1);

    // back-to-back burst
    b0 = beats;
    fr_q.push_back(mk(8'h01, 1'b0, 1'b0, 0));
    fr_q.push_back(mk(8'h02, 1'b0, 1'b0, 0));
    fr_q.push_back(mk(8'h03, 1'b0, 1'b0, 40));
    run("s2", 1'b0);
    check("s2_beats", beats - b0, 3);
    check("s2_beat", last_beat, 9'h103);

    // framing error then good byte
    b0 = beats;
    f0 = ferr_cnt;
    fr_q.push_back(mk(8'h55, 1'b1, 1'b0, 2));
    fr_q.push_back(mk(8'h66, 1'b0, 1'b0, 40));
    run("s3", 1'b0);
    check("s3_beats", beats - b0, 1);
    check("s3_frame_errs", ferr_cnt - f0, 1);
    check("s3_beat", last_beat, 9'h166);

    // glitch shorter than half a bit
    b0 = beats;
    f0 = ferr_cnt + perr_cnt + ovr_cnt;
    drive(1'b0, 4);
    drive(1'b1, 400);
    check("s4_beats", beats - b0, 0);
    check("s4_errs", ferr_cnt + perr_cnt + ovr_cnt - f0, 0);

    // stalled sink overrun
    b0 = beats;
    f0 = ovr_cnt;
    #1 m_axis_ready = 1'b0;
    fr_q.push_back(mk(8'h11, 1'b0, 1'b0, 0));
    fr_q.push_back(mk(8'h22, 1'b0, 1'b0, 0));
    fr_q.push_back(mk(8'h33, 1'b0, 1'b0, 2));
    run("s5", 1'b1);
    check("s5_beats", beats - b0, 2);
    check("s5_overruns", ovr_cnt - f0, 1);
    check("s5_beat", last_beat, 9'h022);

    // random frames with random backpressure
    rand_rdy = 1'b1;
    fork
      while (rand_rdy) begin
        @(posedge clk);
        #1 m_axis_ready = ($urandom_range(3) != 0);
      end
    join_none
    for (int i = 0; i < 30; i++) begin
      fr_q.push_back(mk(8'($urandom), $urandom_range(7) == 0,
                        PAR && ($urandom_range(7) == 0),
                        ($urandom_range(1) != 0) ?
                          int'($urandom_range(3, 1)) :
                          int'($urandom_range(28, 24))));
    end
    run("rand", 1'b0);
    rand_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1 m_axis_ready = 1'b1;

    // reset during data bits with the line held low
    b0 = beats;
    drive(1'b0, OS);
    drive(1'b1, OS);
    drive(1'b1, OS);
    drive(1'b1, OS);
    drive(1'b0, 8);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("s6_reset_outputs", {m_axis_valid, m_axis_last, m_axis_data,
                               frame_err, overrun, parity_err}, 0);
    rst = 1'b1;
    repeat (40) @(posedge clk);
    drive(1'b1, 40);
    fr_q.push_back(mk(8'h88, 1'b0, PAR, 40));
    run("s6", 1'b0);
    check("s6_beats", beats - b0, PAR ? 0 : 1);
    if (!PAR) check("s6_beat", last_beat, 9'h188);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
